i2c_codec_target: RTL
=====================

I2C_CODEC_TARGET -- requirements
Module: i2c_codec_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'b0011010, which is the 7-bit I2C target address the block answers to.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port scl_in, input, 1 bit: raw SCL from the bus, asynchronous to clk.
REQ-005 SHALL have port sda_in, input, 1 bit: raw SDA from the bus, asynchronous to clk.
REQ-006 SHALL have port sda_oe, output, 1 bit: 1 = pull SDA low; 0 = release SDA.
REQ-007 SHALL have port reg_wr_valid, output, 1 bit: one-cycle pulse when a register is written from the bus.
REQ-008 SHALL have port reg_wr_addr, output, 4 bits: register index of the last bus write.
REQ-009 SHALL have port reg_wr_data, output, 8 bits: data of the last bus write.
REQ-010 SHALL have port host_rd_addr, input, 4 bits: local read index into the register file.
REQ-011 SHALL have port host_rd_data, output, 8 bits: regs[host_rd_addr], combinational.
REQ-012 SHALL have port busy, output, 1 bit: 1 from an addressed START to the following STOP.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-flop synchronizers, then a third register for edge detection; bus timing is sampled-only, and each SCL phase SHALL last at least 4 clk cycles.
REQ-014 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-015 SHALL sample data bits on the SCL rising edge, MSB first.
REQ-016 SHALL change sda_oe only in the cycle after an SCL falling edge.
REQ-017 SHALL hold a register file of 16 x 8 bits, all 8'h00 after reset.
REQ-018 SHALL implement the states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK_CHK and WAIT_STOP.
REQ-019 IDLE SHALL move to DEV_ADDR on START; bit counter cleared.
REQ-020 In DEV_ADDR, after 8 bits: if addr[7:1] == DEV_ADDR, the block SHALL go to DEV_ACK and assert sda_oe for the 9th clock; otherwise it SHALL go to WAIT_STOP with sda_oe = 0 (NACK).
REQ-021 DEV_ACK SHALL release sda_oe after the 9th SCL falling edge, then go to REG_ADDR if R/W = 0 or RD_DATA if R/W = 1.
REQ-022 In REG_ADDR, a byte with [7:4] == 0 SHALL load ptr = byte[3:0] and be ACKed (REG_ACK -> WR_DATA); a byte with [7:4] != 0 SHALL be NACKed and go to WAIT_STOP.
REQ-023 In WR_DATA, after 8 bits the block SHALL write regs[ptr], pulse reg_wr_valid for 1 clk with reg_wr_addr = ptr, ACK in WR_ACK, set ptr = ptr + 1 (mod 16), and return to WR_DATA.
REQ-024 In RD_DATA, the block SHALL drive regs[ptr] MSB first, with sda_oe = ~bit, updated after each SCL fall; the first bit is driven after the ACK-bit falling edge.
REQ-025 In RD_ACK_CHK, the block SHALL release SDA and sample the master bit; on ACK (0) it SHALL set ptr = ptr + 1 (mod 16) and go to RD_DATA; on NACK (1) it SHALL go to WAIT_STOP.
REQ-026 A START in any state, including mid-byte, SHALL abort the current byte, release SDA and go to DEV_ADDR, with ptr retained (repeated-start read).
REQ-027 A STOP in any state SHALL release SDA, go to IDLE and clear busy; a partial byte SHALL be discarded with no register write.
REQ-028 WAIT_STOP SHALL ignore all bits and never drive SDA.
REQ-029 A bus write and a host read of the same index in the same cycle SHALL return the old value on host_rd_data until the next cycle.

Reset
REQ-030 On reset assertion the block SHALL immediately set sda_oe = 0, reg_wr_valid = 0, reg_wr_addr = 0, reg_wr_data = 0, busy = 0, state = IDLE, ptr = 0, regs = 0 and synchronizers = 1, including mid-transfer.
REQ-031 After reset release, the block SHALL ignore the bus until the first START.

Verification
REQ-032 Write [0x34, 0x05, 0xA7, STOP] -> ACK on all 3 bytes; reg_wr_valid pulse with addr 5, data 0xA7; regs[5] = 0xA7; busy falls at STOP.
REQ-033 Write [0x34, 0x0F, 0x11, 0x22] then read via START [0x35] -> regs[15] = 0x11 and regs[0] = 0x22 (wrap); ptr = 1.
REQ-034 Preload regs[3] = 0x5C; send [0x34, 0x03], repeated START, [0x35], master NACK -> target shifts 0x5C, releases SDA, reaches WAIT_STOP.
REQ-035 Send [0x36, ...] (wrong address) -> 9th bit SDA high (NACK), no reg_wr_valid, busy = 0; send [0x34, 0x20] -> second byte NACKed.
REQ-036 Assert reset during RD_DATA while driving a 0 -> sda_oe = 0 within the same cycle; a subsequent write transaction completes normally.
REQ-037 START injected after 4 bits of a data byte -> no register write, restarts at DEV_ADDR, next address byte ACKed.

Source files
------------

// File: rtl/i2c_codec_target.sv
// I2C target exposing a 16 x 8 register file: pointer byte, then auto-incrementing writes/reads.
// Bus is oversampled on clk through 2-flop synchronizers; SDA is only ever pulled low, never driven high.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR = 7'b0011010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_valid,
  output logic [3:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  input  logic [3:0] host_rd_addr,
  output logic [7:0] host_rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR, S_REG_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK_CHK, S_WAIT_STOP
  } state_t;

  state_t     state_q;
  logic [2:0] scl_q, sda_q;
  logic [7:0] shreg_q;
  logic [3:0] cnt_q;
  logic [3:0] ptr_q;
  logic [7:0] regs_q [16];
  logic       sda_oe_q, wr_vld_q, busy_q;
  logic [3:0] wr_addr_q;
  logic [7:0] wr_data_q;

  logic       scl_hi, scl_rise, scl_fall, start_det, stop_det, sda_bit, byte_done, rx_state;
  logic [3:0] ptr_inc;

  // [0],[1] synchronize; [2] holds the previous synchronized sample for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign scl_hi    = scl_q[1] & scl_q[2];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_hi & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_hi & sda_q[1] & ~sda_q[2];
  assign sda_bit   = sda_q[1];
  assign byte_done = (cnt_q == 4'd8);
  assign ptr_inc   = ptr_q + 4'd1;
  assign rx_state  = (state_q == S_DEV_ADDR) || (state_q == S_REG_ADDR) || (state_q == S_WR_DATA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= 8'h00;
      cnt_q     <= 4'd0;
      ptr_q     <= 4'd0;
      sda_oe_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= 4'd0;
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_vld_q <= 1'b0;
      if (start_det) begin
        state_q  <= S_DEV_ADDR;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        if (rx_state && scl_rise && !byte_done) begin
          shreg_q <= {shreg_q[6:0], sda_bit};
          cnt_q   <= cnt_q + 4'd1;
        end
        // Each received byte is acted on at the falling edge that ends its 8th bit
        case (state_q)
          S_DEV_ADDR: if (scl_fall && byte_done) begin
            cnt_q <= 4'd0;
            if (shreg_q[7:1] == DEV_ADDR) begin
              state_q  <= S_DEV_ACK;
              sda_oe_q <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q  <= S_WAIT_STOP;
            end
          end
          S_DEV_ACK: if (scl_fall) begin
            if (shreg_q[0]) begin
              state_q  <= S_RD_DATA;
              shreg_q  <= regs_q[ptr_q];
              sda_oe_q <= ~regs_q[ptr_q][7];
            end else begin
              state_q  <= S_REG_ADDR;
              sda_oe_q <= 1'b0;
            end
          end
          S_REG_ADDR: if (scl_fall && byte_done) begin
            cnt_q <= 4'd0;
            if (shreg_q[7:4] == 4'd0) begin
              ptr_q    <= shreg_q[3:0];
              sda_oe_q <= 1'b1;
              state_q  <= S_REG_ACK;
            end else begin
              state_q  <= S_WAIT_STOP;
            end
          end
          S_REG_ACK, S_WR_ACK: if (scl_fall) begin
            sda_oe_q <= 1'b0;
            state_q  <= S_WR_DATA;
          end
          S_WR_DATA: if (scl_fall && byte_done) begin
            cnt_q         <= 4'd0;
            regs_q[ptr_q] <= shreg_q;
            wr_vld_q      <= 1'b1;
            wr_addr_q     <= ptr_q;
            wr_data_q     <= shreg_q;
            ptr_q         <= ptr_inc;
            sda_oe_q      <= 1'b1;
            state_q       <= S_WR_ACK;
          end
          S_RD_DATA: if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              cnt_q    <= 4'd0;
              sda_oe_q <= 1'b0;
              state_q  <= S_RD_ACK_CHK;
            end else begin
              cnt_q    <= cnt_q + 4'd1;
              shreg_q  <= {shreg_q[6:0], 1'b0};
              sda_oe_q <= ~shreg_q[6];
            end
          end
          // A fall seen here means the master ACKed on the preceding rise
          S_RD_ACK_CHK: begin
            if (scl_rise && sda_bit) begin
              state_q <= S_WAIT_STOP;
            end else if (scl_fall) begin
              ptr_q    <= ptr_inc;
              shreg_q  <= regs_q[ptr_inc];
              sda_oe_q <= ~regs_q[ptr_inc][7];
              state_q  <= S_RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe       = sda_oe_q;
  assign reg_wr_valid = wr_vld_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign host_rd_data = regs_q[host_rd_addr];

endmodule
